fitness_eval_ctrl: RTL and testbench

FITNESS_EVAL_CTRL -- requirements
Module: fitness_eval_ctrl

---
 rtl/fitness_eval_ctrl_pkg.sv | 24 ++
 rtl/fec_best_tracker.sv | 29 ++
 rtl/fitness_eval_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fitness_eval_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_eval_ctrl_pkg.sv
// rtl/fitness_eval_ctrl_pkg.sv - shared state type, config address map and default widths
package fitness_eval_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_DRAIN,
    ST_DONE
  } fec_state_e;

  // Config memory: self energies first, then the interaction matrix row-major
  localparam logic [3:0] SE_BASE  = 4'd0;
  localparam logic [3:0] IE_BASE  = 4'd3;
  localparam logic [3:0] CFG_LAST = 4'd11;

  localparam int DEF_NUM_PARTICLE_TYPE = 3;
  localparam int DEF_DATA_WIDTH        = 4;
  localparam int DEF_INDIVIDUAL_LENGTH = 22;
  localparam int DEF_SELF_FIT_LENGTH   = 10;
  localparam int DEF_POP_SIZE          = 50;
  localparam int DEF_IDX_WIDTH         = 8;

endpackage

// File: rtl/fec_best_tracker.sv
// rtl/fec_best_tracker.sv - running minimum of evaluator energies; earliest result wins ties
module fec_best_tracker #(
  parameter int SELF_FIT_LENGTH = 10,
  parameter int IDX_WIDTH       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       valid_i,
  input  logic [SELF_FIT_LENGTH-1:0] energy_i,
  input  logic [IDX_WIDTH-1:0]       idx_i,
  output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
  output logic [IDX_WIDTH-1:0]       best_idx_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      best_energy_o <= '1;
      best_idx_o    <= '0;
    end else if (clear_i) begin
      best_energy_o <= '1;
      best_idx_o    <= '0;
    end else if (valid_i && (energy_i < best_energy_o)) begin
      best_energy_o <= energy_i;
      best_idx_o    <= idx_i;
    end
  end

endmodule

// File: rtl/fitness_eval_ctrl.sv
// rtl/fitness_eval_ctrl.sv - sequences config load, population issue and fitness writeback
// Optional best-fitness tracking is built when FEC_BEST_TRACK_EN is defined.
module fitness_eval_ctrl
  import fitness_eval_ctrl_pkg::*;
#(
  parameter int NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int INDIVIDUAL_LENGTH = DEF_INDIVIDUAL_LENGTH,
  parameter int SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH,
  parameter int POP_SIZE          = DEF_POP_SIZE,
  parameter int IDX_WIDTH         = DEF_IDX_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         pause_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_rd_o,
  output logic [3:0]                   cfg_addr_o,
  input  logic [DATA_WIDTH-1:0]        cfg_data_i,
  output logic                         pop_rd_o,
  output logic [IDX_WIDTH-1:0]         pop_addr_o,
  input  logic [INDIVIDUAL_LENGTH-1:0] pop_data_i,
  output logic                         ev_wr_se_o,
  output logic                         ev_wr_ie_o,
  output logic                         ev_in_valid_o,
  output logic [DATA_WIDTH-1:0]        ev_self_energy_o,
  output logic [DATA_WIDTH-1:0]        ev_interact_energy_o,
  output logic [INDIVIDUAL_LENGTH-1:0] ev_individual_o,
  output logic [IDX_WIDTH-1:0]         ev_idx_o,
  input  logic                         ev_out_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]   ev_energy_i,
  input  logic [IDX_WIDTH-1:0]         ev_idx_i,
  output logic                         fit_we_o,
  output logic [IDX_WIDTH-1:0]         fit_addr_o,
  output logic [SELF_FIT_LENGTH-1:0]   fit_data_o,
  output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
  output logic [IDX_WIDTH-1:0]         best_idx_o
);

  localparam logic [3:0] LOAD_LAST =
    4'(int'(IE_BASE) + NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);
  localparam logic [IDX_WIDTH-1:0] POP_CNT  = IDX_WIDTH'(POP_SIZE);

  fec_state_e           state;
  logic [IDX_WIDTH-1:0] issue_idx;
  logic [IDX_WIDTH-1:0] result_cnt;
  logic                 start_accept;
  logic                 result_accept;

  assign start_accept  = (state == ST_IDLE) && start_i;
  assign result_accept = (state != ST_IDLE) && ev_out_valid_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      cfg_rd_o   <= 1'b0;
      cfg_addr_o <= '0;
      pop_rd_o   <= 1'b0;
      pop_addr_o <= '0;
      issue_idx  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_LOAD;
            busy_o     <= 1'b1;
            cfg_rd_o   <= 1'b1;
            cfg_addr_o <= SE_BASE;
            pop_addr_o <= '0;
            issue_idx  <= '0;
          end
        end
        ST_LOAD: begin
          if (cfg_addr_o == LOAD_LAST) begin
            cfg_rd_o <= 1'b0;
            state    <= ST_EVAL;
          end else begin
            cfg_addr_o <= cfg_addr_o + 4'd1;
          end
        end
        ST_EVAL: begin
          // A paused cycle issues nothing and leaves the presented address in place
          if (!pause_i) begin
            pop_rd_o   <= 1'b1;
            pop_addr_o <= issue_idx;
            issue_idx  <= issue_idx + 1'b1;
            if (issue_idx == LAST_IDX) state <= ST_DRAIN;
          end else begin
            pop_rd_o <= 1'b0;
          end
        end
        ST_DRAIN: begin
          pop_rd_o <= 1'b0;
          if (result_cnt == POP_CNT) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (start_accept) begin
      result_cnt <= '0;
    end else if (result_accept) begin
      result_cnt <= result_cnt + 1'b1;
    end
  end

  // Read data arrives the cycle after the request, so strobes trail the reads by one
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ev_wr_se_o    <= 1'b0;
      ev_wr_ie_o    <= 1'b0;
      ev_in_valid_o <= 1'b0;
      ev_idx_o      <= '0;
      fit_we_o      <= 1'b0;
      fit_addr_o    <= '0;
      fit_data_o    <= '0;
    end else begin
      ev_wr_se_o    <= cfg_rd_o && (cfg_addr_o < IE_BASE);
      ev_wr_ie_o    <= cfg_rd_o && (cfg_addr_o >= IE_BASE);
      ev_in_valid_o <= pop_rd_o;
      ev_idx_o      <= pop_addr_o;
      fit_we_o      <= result_accept;
      if (result_accept) begin
        fit_addr_o <= ev_idx_i;
        fit_data_o <= ev_energy_i;
      end
    end
  end

  assign ev_self_energy_o     = ev_wr_se_o ? cfg_data_i : '0;
  assign ev_interact_energy_o = ev_wr_ie_o ? cfg_data_i : '0;
  assign ev_individual_o      = ev_in_valid_o ? pop_data_i : '0;

`ifdef FEC_BEST_TRACK_EN
  fec_best_tracker #(
    .SELF_FIT_LENGTH(SELF_FIT_LENGTH),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_best_tracker (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .clear_i      (start_accept),
    .valid_i      (result_accept),
    .energy_i     (ev_energy_i),
    .idx_i        (ev_idx_i),
    .best_energy_o(best_energy_o),
    .best_idx_o   (best_idx_o)
  );
`else
  assign best_energy_o = '0;
  assign best_idx_o    = '0;
`endif

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// tb/tb_fitness_eval_ctrl.sv - directed/random bench with memory and fixed-latency evaluator models
module tb_fitness_eval_ctrl;
  localparam int POP = 50;
  localparam int DW  = 4;
  localparam int IL  = 22;
  localparam int FL  = 10;
  localparam int IW  = 8;
  localparam int LAT = 4;

  logic          clk_i = 1'b0;
  logic          rst_n, start_i, pause_i;
  logic          busy_o, done_o, cfg_rd_o, pop_rd_o;
  logic [3:0]    cfg_addr_o;
  logic [DW-1:0] cfg_data_i;
  logic [IW-1:0] pop_addr_o;
  logic [IL-1:0] pop_data_i;
  logic          ev_wr_se_o, ev_wr_ie_o, ev_in_valid_o;
  logic [DW-1:0] ev_self_energy_o, ev_interact_energy_o;
  logic [IL-1:0] ev_individual_o;
  logic [IW-1:0] ev_idx_o;
  logic          ev_out_valid_i;
  logic [FL-1:0] ev_energy_i;
  logic [IW-1:0] ev_idx_i;
  logic          fit_we_o;
  logic [IW-1:0] fit_addr_o;
  logic [FL-1:0] fit_data_o;
  logic [FL-1:0] best_energy_o;
  logic [IW-1:0] best_idx_o;

  fitness_eval_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .pause_i(pause_i),
    .busy_o(busy_o), .done_o(done_o),
    .cfg_rd_o(cfg_rd_o), .cfg_addr_o(cfg_addr_o), .cfg_data_i(cfg_data_i),
    .pop_rd_o(pop_rd_o), .pop_addr_o(pop_addr_o), .pop_data_i(pop_data_i),
    .ev_wr_se_o(ev_wr_se_o), .ev_wr_ie_o(ev_wr_ie_o), .ev_in_valid_o(ev_in_valid_o),
    .ev_self_energy_o(ev_self_energy_o), .ev_interact_energy_o(ev_interact_energy_o),
    .ev_individual_o(ev_individual_o), .ev_idx_o(ev_idx_o),
    .ev_out_valid_i(ev_out_valid_i), .ev_energy_i(ev_energy_i), .ev_idx_i(ev_idx_i),
    .fit_we_o(fit_we_o), .fit_addr_o(fit_addr_o), .fit_data_o(fit_data_o),
    .best_energy_o(best_energy_o), .best_idx_o(best_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous-read memories: data valid the cycle after the request
  logic [DW-1:0] cfg_mem [16];
  logic [IL-1:0] pop_mem [256];
  always @(posedge clk_i) begin
    if (cfg_rd_o) cfg_data_i <= cfg_mem[cfg_addr_o];
    if (pop_rd_o) pop_data_i <= pop_mem[pop_addr_o];
  end

  // Evaluator: energy is the low bits of the individual, returned LAT cycles later
  typedef struct { int due; logic [FL-1:0] e; logic [IW-1:0] idx; } res_t;
  res_t evq[$];
  res_t r;
  logic          m_valid = 1'b0, inj_valid = 1'b0;
  logic [FL-1:0] m_e = '0, inj_e = '0;
  logic [IW-1:0] m_idx = '0, inj_idx = '0;
  int in_cnt, in_err;
  assign ev_out_valid_i = m_valid | inj_valid;
  assign ev_energy_i    = inj_valid ? inj_e : m_e;
  assign ev_idx_i       = inj_valid ? inj_idx : m_idx;

  always @(negedge clk_i) begin
    m_valid = 1'b0;
    if (!rst_n) begin
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].due <= cyc) begin
        r = evq.pop_front();
        m_valid = 1'b1; m_e = r.e; m_idx = r.idx;
      end
      if (ev_in_valid_o) begin
        in_cnt++;
        if (ev_individual_o !== pop_mem[ev_idx_o]) in_err++;
        evq.push_back('{due: cyc + LAT, e: ev_individual_o[FL-1:0], idx: ev_idx_o});
      end
    end
  end

  int cfg_a[$], cfg_c[$], wr_k[$], wr_d[$], wr_c[$], pop_a[$], pop_c[$];
  int wb_cnt [256];
  int wb_dat [256];
  int wb_total, last_wb_cyc, done_cnt, done_cyc, strobe_err;

  always @(negedge clk_i) begin
    if (cfg_rd_o) begin cfg_a.push_back(int'(cfg_addr_o)); cfg_c.push_back(cyc); end
    if (ev_wr_se_o && ev_wr_ie_o) strobe_err++;
    if (ev_wr_se_o) begin wr_k.push_back(0); wr_d.push_back(int'(ev_self_energy_o)); wr_c.push_back(cyc); end
    if (ev_wr_ie_o) begin wr_k.push_back(1); wr_d.push_back(int'(ev_interact_energy_o)); wr_c.push_back(cyc); end
    if (pop_rd_o) begin pop_a.push_back(int'(pop_addr_o)); pop_c.push_back(cyc); end
    if (fit_we_o) begin
      wb_total++; wb_cnt[fit_addr_o]++; wb_dat[fit_addr_o] = int'(fit_data_o); last_wb_cyc = cyc;
    end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
  end

  int n_asserts = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cfg_a.delete(); cfg_c.delete(); wr_k.delete(); wr_d.delete(); wr_c.delete();
    pop_a.delete(); pop_c.delete();
    foreach (wb_cnt[i]) begin wb_cnt[i] = 0; wb_dat[i] = 0; end
    wb_total = 0; last_wb_cyc = 0; done_cnt = 0; done_cyc = 0; strobe_err = 0;
    in_cnt = 0; in_err = 0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) cfg_mem[i] = DW'($urandom);
    for (int i = 0; i < 256; i++) pop_mem[i] = IL'($urandom);
  endtask

  task automatic start_gen();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin @(negedge clk_i); n++; end
    chk("done_seen", {31'd0, done_o}, 32'd1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_pop(input int a, input int budget);
    int n = 0;
    while (!(pop_rd_o === 1'b1 && int'(pop_addr_o) == a) && n < budget) begin
      @(negedge clk_i); n++;
    end
    chk($sformatf("pop_reach_%0d", a), {31'd0, pop_rd_o}, 32'd1);
  endtask

  task automatic check_gen(input string tag, input int pause_at, input int pause_len);
    logic [FL-1:0] be;
    int bi, gap;
    chk({tag, " cfg_reads"}, cfg_a.size(), 12);
    for (int i = 0; i < 12 && i < cfg_a.size(); i++) begin
      chk($sformatf("%s cfg_addr[%0d]", tag, i), cfg_a[i], i);
      chk($sformatf("%s cfg_cyc[%0d]", tag, i), cfg_c[i], cfg_c[0] + i);
    end
    chk({tag, " cfg_writes"}, wr_k.size(), 12);
    chk({tag, " strobe_overlap"}, strobe_err, 0);
    for (int i = 0; i < 12 && i < wr_k.size() && cfg_c.size() > 0; i++) begin
      chk($sformatf("%s wr_kind[%0d]", tag, i), wr_k[i], (i < 3) ? 0 : 1);
      chk($sformatf("%s wr_data[%0d]", tag, i), wr_d[i], int'(cfg_mem[i]));
      chk($sformatf("%s wr_cyc[%0d]", tag, i), wr_c[i], cfg_c[0] + 1 + i);
    end
    chk({tag, " pop_reads"}, pop_a.size(), POP);
    for (int i = 0; i < POP && i < pop_a.size(); i++) begin
      gap = (pause_at >= 0 && i > pause_at) ? pause_len : 0;
      chk($sformatf("%s pop_addr[%0d]", tag, i), pop_a[i], i);
      chk($sformatf("%s pop_cyc[%0d]", tag, i), pop_c[i], pop_c[0] + i + gap);
    end
    chk({tag, " ev_in_count"}, in_cnt, POP);
    chk({tag, " ev_in_data_err"}, in_err, 0);
    chk({tag, " wb_total"}, wb_total, POP);
    for (int i = 0; i < POP; i++) begin
      chk($sformatf("%s wb_cnt[%0d]", tag, i), wb_cnt[i], 1);
      chk($sformatf("%s wb_data[%0d]", tag, i), wb_dat[i], int'(pop_mem[i][FL-1:0]));
    end
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " done_after_last_wb"}, done_cyc, last_wb_cyc + 1);
    chk({tag, " busy_after"}, {31'd0, busy_o}, 32'd0);
    be = '1; bi = 0;
    for (int i = 0; i < POP; i++)
      if (pop_mem[i][FL-1:0] < be) begin be = pop_mem[i][FL-1:0]; bi = i; end
`ifdef FEC_BEST_TRACK_EN
    chk({tag, " best_energy"}, 32'(best_energy_o), 32'(be));
    chk({tag, " best_idx"}, 32'(best_idx_o), bi);
`else
    chk({tag, " best_energy"}, 32'(best_energy_o), 32'd0);
    chk({tag, " best_idx"}, 32'(best_idx_o), 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " done"}, {31'd0, done_o}, 32'd0);
    chk({tag, " cfg_rd"}, {31'd0, cfg_rd_o}, 32'd0);
    chk({tag, " pop_rd"}, {31'd0, pop_rd_o}, 32'd0);
    chk({tag, " pop_addr"}, 32'(pop_addr_o), 32'd0);
    chk({tag, " fit_we"}, {31'd0, fit_we_o}, 32'd0);
    chk({tag, " ev_in_valid"}, {31'd0, ev_in_valid_o}, 32'd0);
`ifdef FEC_BEST_TRACK_EN
    chk({tag, " best_energy"}, 32'(best_energy_o), 32'h3ff);
`else
    chk({tag, " best_energy"}, 32'(best_energy_o), 32'd0);
`endif
    chk({tag, " best_idx"}, 32'(best_idx_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; pause_i = 1'b0;
    clear_mon();
    randomize_mem();
    repeat (3) @(negedge clk_i);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Plain generation with random config and population
    clear_mon();
    start_gen();
    wait_done(2000);
    check_gen("gen1", -1, 0);

    // Pause at address 10, best-energy pattern, pause held through drain
    randomize_mem();
    for (int i = 0; i < POP; i++) pop_mem[i][FL-1:0] = FL'($urandom_range(100, 1023));
    pop_mem[0][FL-1:0] = 10'd20;
    pop_mem[1][FL-1:0] = 10'd7;
    pop_mem[2][FL-1:0] = 10'd7;
    pop_mem[3][FL-1:0] = 10'd9;
    pop_mem[40][FL-1:0] = 10'd3;
    clear_mon();
    start_gen();
    wait_pop(10, 200);
    pause_i = 1'b1;
    repeat (5) @(negedge clk_i);
    pause_i = 1'b0;
    wait_pop(49, 200);
    pause_i = 1'b1;
    wait_done(500);
    pause_i = 1'b0;
    check_gen("gen2", 10, 5);
`ifdef FEC_BEST_TRACK_EN
    chk("gen2 best_is_3", 32'(best_energy_o), 32'd3);
    chk("gen2 best_idx_40", 32'(best_idx_o), 32'd40);
`endif

    // Results arriving while idle must be dropped
    clear_mon();
    @(negedge clk_i);
    inj_valid = 1'b1; inj_e = 10'd1; inj_idx = 8'd5;
    @(negedge clk_i);
    inj_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("idle_result wb_total", wb_total, 0);
    chk("idle_result busy", {31'd0, busy_o}, 32'd0);

    // Start pulsed mid-evaluation is ignored
    randomize_mem();
    clear_mon();
    start_gen();
    wait_pop(20, 200);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(2000);
    check_gen("gen3", -1, 0);

    // Reset mid-generation aborts without a done pulse
    clear_mon();
    start_gen();
    wait_pop(25, 200);
    rst_n = 1'b0;
    #1;
    chk("abort busy_immediate", {31'd0, busy_o}, 32'd0);
    chk("abort pop_rd_immediate", {31'd0, pop_rd_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    check_reset_state("abort");
    rst_n = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("abort no_done", done_cnt, 0);
    chk("abort idle_busy", {31'd0, busy_o}, 32'd0);

    randomize_mem();
    clear_mon();
    start_gen();
    wait_done(2000);
    check_gen("gen4", -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
